// File: rtl/if_fetch_unit.sv
// Instruction fetch unit.
// Issues one instruction-SRAM read at a time from pc_reg. The returned word is
// either handed straight to the IF/ID bus or, when IF/ID is stalled, parked in
// a one-entry buffer. Branch redirects from decode arrive combinationally; if
// they arrive outside a handoff cycle they are remembered as a pending target,
// so the delay-slot instruction already in flight is always delivered.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [2:0]  stall,
  input  logic [32:0] br_bus,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  output logic [65:0] if_to_id_bus
);

  // Stall vector bit positions
  localparam int unsigned StallPc   = 0;
  localparam int unsigned StallIfId = 1;
  localparam int unsigned StallIdEx = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        buf_adel_q, buf_adel_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [65:0] bus_q, bus_d;

  logic        br_e;
  logic [31:0] br_addr;
  logic        aligned;
  logic        handoff;
  logic        hand_adel;
  logic [31:0] hand_inst;
  logic [31:0] next_pc;

  assign br_e    = br_bus[32];
  assign br_addr = br_bus[31:0];
  assign aligned = (pc_q[1:0] == 2'b00);

  // A handoff delivers either the live SRAM word (WAIT) or the parked one (HOLD)
  assign handoff = ~stall[StallIfId] &
                   (((state_q == WAIT) & inst_sram_data_ok) | (state_q == HOLD));
  assign hand_adel = (state_q == HOLD) ? buf_adel_q : 1'b0;
  assign hand_inst = (state_q == HOLD) ? buf_inst_q : inst_sram_rdata;

  // A same-cycle redirect wins over a remembered one; otherwise fall through
  assign next_pc = br_e     ? br_addr :
                   pend_v_q ? pend_tgt_q :
                              pc_q + 32'd4;

  // Misaligned PCs never reach the SRAM; stall[0] only gates new requests
  assign inst_sram_req  = (state_q == REQ) & aligned & ~stall[StallPc];
  assign inst_sram_addr = pc_q;
  assign if_to_id_bus   = bus_q;

  // FSM transitions and fetch buffer capture
  always_comb begin
    state_d    = state_q;
    buf_adel_d = buf_adel_q;
    buf_inst_d = buf_inst_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (!aligned) begin
          // Address error: fabricate an instruction-less entry flagged adel
          buf_adel_d = 1'b1;
          buf_inst_d = 32'd0;
          state_d    = HOLD;
        end else if (inst_sram_req && inst_sram_addr_ok) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (inst_sram_data_ok) begin
          if (stall[StallIfId]) begin
            buf_adel_d = 1'b0;
            buf_inst_d = inst_sram_rdata;
            state_d    = HOLD;
          end else begin
            state_d = REQ;
          end
        end
      end
      HOLD: begin
        if (!stall[StallIfId]) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  // PC advance and pending-branch bookkeeping
  always_comb begin
    pc_d       = pc_q;
    pend_v_d   = pend_v_q;
    pend_tgt_d = pend_tgt_q;
    if (handoff) begin
      pc_d     = next_pc;
      pend_v_d = 1'b0;
    end else if (br_e) begin
      pend_v_d   = 1'b1;
      pend_tgt_d = br_addr;
    end
  end

  // IF/ID register: load on handoff, bubble when ID can accept, else hold
  always_comb begin
    bus_d = bus_q;
    if (handoff) begin
      bus_d = {hand_adel, 1'b1, pc_q, hand_inst};
    end else if (!stall[StallIfId]) begin
      bus_d = 66'd0;
    end else if (!stall[StallIdEx]) begin
      bus_d = 66'd0;
    end
  end

  // State registers; reset abandons any outstanding request
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      pend_v_q   <= 1'b0;
      pend_tgt_q <= 32'd0;
      buf_adel_q <= 1'b0;
      buf_inst_q <= 32'd0;
      bus_q      <= 66'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_v_q   <= pend_v_d;
      pend_tgt_q <= pend_tgt_d;
      buf_adel_q <= buf_adel_d;
      buf_inst_q <= buf_inst_d;
      bus_q      <= bus_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed testbench for if_fetch_unit.
module tb_if_fetch_unit;

  localparam logic [31:0] RPC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  stall;
  logic [32:0] br_bus;
  logic        req;
  logic [31:0] addr;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic [65:0] bus;
  logic [65:0] prev;

  integer checks = 0;
  integer errors = 0;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .stall             (stall),
    .br_bus            (br_bus),
    .inst_sram_req     (req),
    .inst_sram_addr    (addr),
    .inst_sram_addr_ok (addr_ok),
    .inst_sram_data_ok (data_ok),
    .inst_sram_rdata   (rdata),
    .if_to_id_bus      (bus)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive one clean fetch starting in REQ: accept, then return w next cycle
  task automatic do_fetch(input logic [31:0] w);
    addr_ok = 1'b1;
    cyc();
    addr_ok = 1'b0;
    data_ok = 1'b1;
    rdata   = w;
    cyc();
    data_ok = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; stall = 3'b000; br_bus = 33'd0;
    addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'd0;
    cyc(); cyc();
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req got %b expected 0", req); end
    checks++; if (addr !== RPC) begin errors++; $display("FAIL reset_addr got %h expected %h", addr, RPC); end
    checks++; if (bus !== 66'd0) begin errors++; $display("FAIL reset_bus got %h expected 0", bus); end
    checks++; if (dut.state_q !== 2'd0) begin errors++; $display("FAIL reset_state got %0d expected 0", dut.state_q); end
    checks++; if (dut.pend_v_q !== 1'b0) begin errors++; $display("FAIL reset_pend got %b expected 0", dut.pend_v_q); end
    resetn = 1'b1;
    #1;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL idle_req got %b expected 0", req); end
  endtask

  task automatic test_basic();
    cyc();
    addr_ok = 1'b1;
    #1;
    checks++; if (req !== 1'b1 || addr !== RPC) begin errors++; $display("FAIL first_req got %b/%h expected 1/%h", req, addr, RPC); end
    cyc();
    addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h3C01_1234;
    #1;
    checks++; if (req !== 1'b0 || bus !== 66'd0) begin errors++; $display("FAIL wait_cycle got %b/%h expected 0/0", req, bus); end
    cyc();
    data_ok = 1'b0;
    #1;
    checks++; if (bus !== {1'b0, 1'b1, 32'hBFC0_0000, 32'h3C01_1234}) begin errors++; $display("FAIL first_bus got %h expected %h", bus, {1'b0, 1'b1, 32'hBFC0_0000, 32'h3C01_1234}); end
    checks++; if (req !== 1'b1 || addr !== 32'hBFC0_0004) begin errors++; $display("FAIL second_req got %b/%h expected 1/bfc00004", req, addr); end
    do_fetch(32'h2402_0005);
    checks++; if (bus !== {1'b0, 1'b1, 32'hBFC0_0004, 32'h2402_0005}) begin errors++; $display("FAIL second_bus got %h expected %h", bus, {1'b0, 1'b1, 32'hBFC0_0004, 32'h2402_0005}); end
  endtask

  task automatic test_branch_pending();
    addr_ok = 1'b1;
    cyc();
    addr_ok = 1'b0;
    br_bus = {1'b1, 32'h0000_0F00};
    cyc();
    br_bus = {1'b1, 32'hBFC0_0100};
    #1;
    checks++; if (dut.pend_v_q !== 1'b1 || dut.pend_tgt_q !== 32'h0000_0F00) begin errors++; $display("FAIL pend_set got %b/%h expected 1/00000f00", dut.pend_v_q, dut.pend_tgt_q); end
    cyc();
    br_bus = 33'd0;
    #1;
    checks++; if (dut.pend_tgt_q !== 32'hBFC0_0100 || dut.state_q !== 2'd2) begin errors++; $display("FAIL pend_overwrite got %h/%0d expected bfc00100/2", dut.pend_tgt_q, dut.state_q); end
    data_ok = 1'b1; rdata = 32'h8C22_0000;
    cyc();
    data_ok = 1'b0;
    #1;
    checks++; if (bus !== {1'b0, 1'b1, 32'hBFC0_0008, 32'h8C22_0000}) begin errors++; $display("FAIL delay_slot_bus got %h expected %h", bus, {1'b0, 1'b1, 32'hBFC0_0008, 32'h8C22_0000}); end
    checks++; if (addr !== 32'hBFC0_0100 || req !== 1'b1 || dut.pend_v_q !== 1'b0) begin errors++; $display("FAIL branch_target got %h/%b/%b expected bfc00100/1/0", addr, req, dut.pend_v_q); end
  endtask

  task automatic test_stall();
    prev = {1'b0, 1'b1, 32'hBFC0_0008, 32'h8C22_0000};
    stall = 3'b110; addr_ok = 1'b1;
    #1;
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL stall12_req got %b expected 1", req); end
    cyc();
    addr_ok = 1'b0;
    #1;
    checks++; if (bus !== prev) begin errors++; $display("FAIL stall_hold_wait got %h expected %h", bus, prev); end
    data_ok = 1'b1; rdata = 32'hAAAA_5555;
    for (int i = 0; i < 3; i++) begin
      cyc();
      data_ok = 1'b0;
      #1;
      checks++;
      if (dut.state_q !== 2'd3 || bus !== prev || req !== 1'b0) begin
        errors++; $display("FAIL stall_hold_%0d got %0d/%h/%b expected 3/%h/0", i, dut.state_q, bus, req, prev);
      end
    end
    stall = 3'b000;
    cyc();
    checks++; if (bus !== {1'b0, 1'b1, 32'hBFC0_0100, 32'hAAAA_5555}) begin errors++; $display("FAIL stall_release got %h expected %h", bus, {1'b0, 1'b1, 32'hBFC0_0100, 32'hAAAA_5555}); end
    checks++; if (addr !== 32'hBFC0_0104) begin errors++; $display("FAIL stall_next_addr got %h expected bfc00104", addr); end
    do_fetch(32'h1234_5678);
    checks++; if (bus !== {1'b0, 1'b1, 32'hBFC0_0104, 32'h1234_5678}) begin errors++; $display("FAIL stall_after got %h expected %h", bus, {1'b0, 1'b1, 32'hBFC0_0104, 32'h1234_5678}); end
  endtask

  task automatic test_stall_bubble();
    stall = 3'b010; addr_ok = 1'b1;
    cyc();
    addr_ok = 1'b0;
    #1;
    checks++; if (bus !== 66'd0) begin errors++; $display("FAIL idex_flow_bubble got %h expected 0", bus); end
    data_ok = 1'b1; rdata = 32'h0BAD_F00D;
    cyc();
    data_ok = 1'b0;
    #1;
    checks++; if (dut.state_q !== 2'd3 || bus !== 66'd0) begin errors++; $display("FAIL idex_flow_hold got %0d/%h expected 3/0", dut.state_q, bus); end
    stall = 3'b000;
    cyc();
    checks++; if (bus !== {1'b0, 1'b1, 32'hBFC0_0108, 32'h0BAD_F00D}) begin errors++; $display("FAIL idex_flow_release got %h expected %h", bus, {1'b0, 1'b1, 32'hBFC0_0108, 32'h0BAD_F00D}); end
  endtask

  task automatic test_stall0();
    stall = 3'b001;
    #1;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL stall0_req got %b expected 0", req); end
    cyc();
    checks++; if (dut.state_q !== 2'd1 || addr !== 32'hBFC0_010C) begin errors++; $display("FAIL stall0_stay got %0d/%h expected 1/bfc0010c", dut.state_q, addr); end
    stall = 3'b000; addr_ok = 1'b1;
    #1;
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL stall0_resume got %b expected 1", req); end
    cyc();
    addr_ok = 1'b0; stall = 3'b001; data_ok = 1'b1; rdata = 32'h2108_FFFF;
    cyc();
    data_ok = 1'b0; stall = 3'b000;
    #1;
    checks++; if (bus !== {1'b0, 1'b1, 32'hBFC0_010C, 32'h2108_FFFF}) begin errors++; $display("FAIL stall0_wait got %h expected %h", bus, {1'b0, 1'b1, 32'hBFC0_010C, 32'h2108_FFFF}); end
  endtask

  task automatic test_branch_handoff();
    addr_ok = 1'b1;
    cyc();
    addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h1000_0040;
    br_bus = {1'b1, 32'hBFC0_0200};
    cyc();
    data_ok = 1'b0; br_bus = 33'd0;
    #1;
    checks++; if (bus !== {1'b0, 1'b1, 32'hBFC0_0110, 32'h1000_0040}) begin errors++; $display("FAIL br_handoff_bus got %h expected %h", bus, {1'b0, 1'b1, 32'hBFC0_0110, 32'h1000_0040}); end
    checks++; if (addr !== 32'hBFC0_0200 || dut.pend_v_q !== 1'b0) begin errors++; $display("FAIL br_handoff_pc got %h/%b expected bfc00200/0", addr, dut.pend_v_q); end
  endtask

  task automatic test_wrap();
    addr_ok = 1'b1;
    cyc();
    addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h03E0_0008;
    br_bus = {1'b1, 32'hFFFF_FFFC};
    cyc();
    data_ok = 1'b0; br_bus = 33'd0;
    #1;
    checks++; if (addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_target got %h expected fffffffc", addr); end
    do_fetch(32'h0000_0001);
    checks++; if (bus !== {1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0001}) begin errors++; $display("FAIL wrap_bus got %h expected %h", bus, {1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0001}); end
    checks++; if (addr !== 32'h0000_0000) begin errors++; $display("FAIL wrap_pc got %h expected 00000000", addr); end
  endtask

  task automatic test_reset_mid();
    addr_ok = 1'b1;
    cyc();
    addr_ok = 1'b0;
    #1;
    checks++; if (dut.state_q !== 2'd2) begin errors++; $display("FAIL rst_mid_wait got %0d expected 2", dut.state_q); end
    resetn = 1'b0;
    #1;
    checks++; if (req !== 1'b0 || addr !== RPC || dut.state_q !== 2'd0) begin errors++; $display("FAIL rst_mid_async got %b/%h/%0d expected 0/%h/0", req, addr, dut.state_q, RPC); end
    cyc();
    resetn = 1'b1; data_ok = 1'b1; rdata = 32'hDEAD_BEEF;
    cyc();
    checks++; if (dut.state_q !== 2'd1 || req !== 1'b1 || addr !== RPC || bus !== 66'd0) begin errors++; $display("FAIL rst_mid_req got %0d/%b/%h/%h expected 1/1/%h/0", dut.state_q, req, addr, bus, RPC); end
    cyc();
    data_ok = 1'b0;
    #1;
    checks++; if (dut.state_q !== 2'd1 || bus !== 66'd0) begin errors++; $display("FAIL rst_mid_ignore got %0d/%h expected 1/0", dut.state_q, bus); end
    do_fetch(32'h3C01_1234);
    checks++; if (bus !== {1'b0, 1'b1, RPC, 32'h3C01_1234}) begin errors++; $display("FAIL rst_mid_refetch got %h expected %h", bus, {1'b0, 1'b1, RPC, 32'h3C01_1234}); end
  endtask

  task automatic test_misaligned();
    addr_ok = 1'b1;
    cyc();
    addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h0000_0002;
    br_bus = {1'b1, 32'hBFC0_0102};
    cyc();
    data_ok = 1'b0; br_bus = 33'd0;
    #1;
    checks++; if (addr !== 32'hBFC0_0102 || req !== 1'b0) begin errors++; $display("FAIL misalign_noreq got %h/%b expected bfc00102/0", addr, req); end
    cyc();
    checks++; if (dut.state_q !== 2'd3 || req !== 1'b0 || bus !== 66'd0) begin errors++; $display("FAIL misalign_hold got %0d/%b/%h expected 3/0/0", dut.state_q, req, bus); end
    cyc();
    checks++; if (bus !== {1'b1, 1'b1, 32'hBFC0_0102, 32'h0000_0000}) begin errors++; $display("FAIL misalign_bus got %h expected %h", bus, {1'b1, 1'b1, 32'hBFC0_0102, 32'h0000_0000}); end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_branch_pending();
    test_stall();
    test_stall_bubble();
    test_stall0();
    test_branch_handoff();
    test_wrap();
    test_reset_mid();
    test_misaligned();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
